prescale_clk_div: RTL
=====================

// Module: prescale_clk_div
// PURPOSE
//  Configurable prescale-to-ratio decoder plus integer clock-enable divider for the
//  UART RX oversampling path. Decodes a power-of-two prescale into
//  ratio = REF_PRESCALE/prescale. Runs a period counter that emits a one-cycle tick
//  and a 50%-duty registered divided level. Ratio changes are deferred to a period
//  boundary so the downstream sampler never sees a truncated period.
// PARAMETERS
//  PRESCALE_W   6   width of i_prescale
//  RATIO_W      8   width of o_div_ratio and of the period counter
//  REF_PRESCALE 32  prescale that gives ratio 1 (power of two)
//  MIN_PRESCALE 8   smallest legal prescale (power of two, <= REF_PRESCALE)
// PORTS
//  CLK          in   1           single clock; everything is synchronous to its rising edge
//  RST          in   1           synchronous, active-high reset
//  i_en         in   1           divider run enable
//  i_prescale   in   PRESCALE_W  requested prescale (8/16/32 at default parameters)
//  i_cfg_load   in   1           one-cycle strobe; capture the decoded i_prescale
//  o_div_ratio  out  RATIO_W     ratio currently in force
//  o_div_tick   out  1           high for one cycle at the end of each divided period
//  o_div_clk    out  1           registered divided level, 50% duty, for ratios >= 2
//  o_cfg_pend   out  1           a captured ratio is waiting for a period boundary
//  o_cfg_err    out  1           present only with PRESCALE_CHK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset: o_div_ratio=1, all other outputs 0, counter 0, pending register 1, state IDLE.
//  - Decode (combinational):
//    - legal = power of two with MIN_PRESCALE <= p <= REF_PRESCALE.
//    - Legal prescale: ratio = REF_PRESCALE >> log2(p). Defaults: 8->4, 16->2, 32->1.
//    - Illegal prescale (0, non-power-of-two, out of range): ratio = 1.
//  - FSM states:
//    - IDLE: i_en=0. Counter held 0; tick=0; div_clk=0.
//    - RUN: counting.
//    - PEND: counting, with a captured ratio waiting.
//  - FSM transitions:
//    - IDLE->RUN on i_en=1.
//    - RUN->PEND on i_cfg_load.
//    - PEND->RUN at the boundary cycle (the tick cycle), where o_div_ratio <= pending.
//    - Any state->IDLE on i_en=0. A pending ratio, if any, is applied immediately on
//      that transition.
//  - Loads outside RUN/PEND:
//    - i_cfg_load in IDLE: o_div_ratio updates on the next edge; state stays IDLE.
//    - i_cfg_load and i_en rising in the same cycle: the new ratio is used for the
//      first period.
//  - Counter: counts 0..ratio-1 while running, then wraps to 0.
//    - o_div_tick = 1 in the cycle where count==ratio-1.
//    - Ratio 1: tick is high every running cycle; o_div_clk stays 0.
//  - o_div_clk (ratio >= 2): high while count < ratio/2, else low.
//    - After IDLE->RUN, the first tick comes ratio cycles after i_en is sampled high.
//  - Simultaneous i_cfg_load and boundary: the new value goes to pending and is applied
//    at the NEXT boundary, not the current one.
//  - Back-to-back loads in PEND: the last one wins; only one ratio is ever pending.
//  - o_cfg_pend = (state==PEND).
//  - RST mid-period: all state returns to reset values on the next edge; a pending
//    ratio is discarded.
// CONFIGURATION
//  PRESCALE_CHK_EN defined:
//    - o_cfg_err port exists.
//    - Set on any i_cfg_load that carries an illegal prescale.
//    - Sticky; cleared by RST or by a later load carrying a legal prescale.
//    - The illegal load still applies ratio 1.
//  PRESCALE_CHK_EN undefined:
//    - Port and logic are absent; illegal prescale silently maps to ratio 1.
// TESTING
//  1. RST=1 for 2 cycles -> o_div_ratio=1, o_div_tick=0, o_div_clk=0, o_cfg_pend=0.
//  2. Load prescale 8 in IDLE, then en=1 ->
//     - ratio 4;
//     - tick every 4th cycle, first tick 4 cycles after en;
//     - div_clk pattern 1100 repeating.
//  3. Running at ratio 4, load 16 at count 1 ->
//     - pend=1;
//     - current period completes with 4 cycles;
//     - then ratio 2, tick every 2nd cycle, pend=0.
//  4. Load 32 in the tick cycle at ratio 2 -> one further full 2-cycle period, then
//     ratio 1 with tick high every cycle and div_clk=0.
//  5. Load 12, then 0 (PRESCALE_CHK_EN on) -> ratio 1 and o_cfg_err=1 after each;
//     then load 16 -> ratio 2, o_cfg_err=0.
//  6. Reset mid-PEND -> pend=0, ratio=1 on the next edge; the pending value is never
//     applied. Also: en=0 mid-period -> tick and div_clk go to 0 on the next edge.

Source files
------------

// File: rtl/prescale_clk_div.sv
// prescale_clk_div: power-of-two prescale to ratio decoder plus a clock-enable
// divider that emits a one-cycle tick and a registered 50% divided level.
// A ratio loaded while counting waits for the end of the current period.
// Optional feature macro: PRESCALE_CHK_EN adds the sticky o_cfg_err flag.
module prescale_clk_div #(
   parameter int PRESCALE_W   = 6,
   parameter int RATIO_W      = 8,
   parameter int REF_PRESCALE = 32,
   parameter int MIN_PRESCALE = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_prescale,
   input  logic                  i_cfg_load,
   output logic [RATIO_W-1:0]    o_div_ratio,
   output logic                  o_div_tick,
   output logic                  o_div_clk,
   output logic                  o_cfg_pend
`ifdef PRESCALE_CHK_EN
   ,
   output logic                  o_cfg_err
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

   localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);
   localparam logic [RATIO_W-1:0] TWO = RATIO_W'(2);

   state_t               r_state;
   logic [RATIO_W-1:0]   r_cnt;
   logic [RATIO_W-1:0]   r_ratio;
   logic [RATIO_W-1:0]   r_pend;
   logic                 r_tick;
   logic                 r_dclk;

   logic                 w_legal;
   logic [RATIO_W-1:0]   w_dec;
   logic                 w_bound;
   state_t               w_state_n;
   logic [RATIO_W-1:0]   w_cnt_n;
   logic [RATIO_W-1:0]   w_ratio_n;
   logic [RATIO_W-1:0]   w_pend_n;

   // Decode: a legal prescale is a single power of two within range; anything else is ratio 1.
   always_comb begin
      w_legal = 1'b0;
      w_dec   = ONE;
      for (int i = 0; i < PRESCALE_W; i++) begin
         if ((i_prescale == PRESCALE_W'(1 << i)) &&
             ((1 << i) >= MIN_PRESCALE) && ((1 << i) <= REF_PRESCALE)) begin
            w_legal = 1'b1;
            w_dec   = RATIO_W'(REF_PRESCALE >> i);
         end
      end
   end

   // Next-state: the boundary is the tick cycle; ratio changes only there or when leaving RUN/PEND.
   always_comb begin
      w_bound   = (r_state != IDLE) && (r_cnt == (r_ratio - ONE));
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_ratio_n = r_ratio;
      w_pend_n  = r_pend;
      if (!i_en) begin
         w_state_n = IDLE;
         w_cnt_n   = '0;
         if (i_cfg_load)
            w_ratio_n = w_dec;
         else if (r_state == PEND)
            w_ratio_n = r_pend;
      end else if (r_state == IDLE) begin
         // Load coinciding with enable rising applies to the very first period.
         w_state_n = RUN;
         w_cnt_n   = '0;
         if (i_cfg_load)
            w_ratio_n = w_dec;
      end else begin
         if (w_bound) begin
            w_cnt_n   = '0;
            w_state_n = RUN;
            if (r_state == PEND)
               w_ratio_n = r_pend;
         end else begin
            w_cnt_n = r_cnt + ONE;
         end
         // A load on the boundary is deferred to the following boundary; last load wins.
         if (i_cfg_load) begin
            w_pend_n  = w_dec;
            w_state_n = PEND;
         end
      end
   end

   // FSM and registered outputs; tick/level are derived from the next count so they align with it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ratio <= ONE;
         r_pend  <= ONE;
         r_tick  <= 1'b0;
         r_dclk  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_ratio <= w_ratio_n;
         r_pend  <= w_pend_n;
         r_tick  <= (w_state_n != IDLE) && (w_cnt_n == (w_ratio_n - ONE));
         r_dclk  <= (w_state_n != IDLE) && (w_ratio_n >= TWO) &&
                    (w_cnt_n < (w_ratio_n >> 1));
      end
   end

`ifdef PRESCALE_CHK_EN
   logic r_err;

   // Sticky illegal-load flag; every load re-evaluates it.
   always_ff @(posedge CLK) begin
      if (RST)
         r_err <= 1'b0;
      else if (i_cfg_load)
         r_err <= ~w_legal;
   end

   assign o_cfg_err = r_err;
`else
   logic w_unused_legal;
   assign w_unused_legal = w_legal;
`endif

   assign o_div_ratio = r_ratio;
   assign o_div_tick  = r_tick;
   assign o_div_clk   = r_dclk;
   assign o_cfg_pend  = (r_state == PEND);

endmodule
